// File: rtl/resnet88_sched_pkg.sv
// Shared types and widths for the resnet88 stream scheduler.
package resnet88_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } sched_state_e;

    localparam int LANE_W  = 4;
    localparam int DATA_W  = 16;
    localparam int COUNT_W = 32;

endpackage

// File: rtl/resnet88_lane_fifo.sv
// Fall-through lane FIFO: the head is visible combinationally and reads 0 when empty.
module resnet88_lane_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic              clear_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              full_o,
    output logic              empty_o,
    output logic [DATA_W-1:0] head_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       wptr_q, wptr_d;
    logic [AW:0]       rptr_q, rptr_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              do_push, do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign head_o  = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

    // Full blocks a push even when a pop happens in the same cycle.
    assign do_push = push_i && !full_o && !clear_i;
    assign do_pop  = pop_i && !empty_o && !clear_i;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (clear_i) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + 1'b1;
            if (do_pop)  rptr_d = rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/resnet88_stream_sched.sv
// Run sequencer and input-stream scheduler for resnet88.
// Optional underflow checking: RESNET88_STREAM_SCHED_UNDERFLOW_CHECK_EN.
module resnet88_stream_sched
    import resnet88_sched_pkg::*;
#(
    parameter int NUM_LANES = 9,
    parameter int NUM_OUT   = 8,
    parameter int DEPTH     = 4,
    parameter int OUT_TOTAL = 4096
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LANE_W-1:0]           in_lane,
    input  logic [DATA_W-1:0]           in_data,
    input  logic [NUM_LANES-1:0]        lane_read_en,
    output logic [NUM_LANES*DATA_W-1:0] lane_data,
    input  logic [NUM_OUT-1:0]          out_write_valid,
    output logic                        dut_flush,
    output logic                        busy,
    output logic                        done,
    output logic [COUNT_W-1:0]          out_count,
    output logic                        underflow_err,
    output logic [LANE_W-1:0]           underflow_lane
);
    // Reset is active-high despite the port name.
    wire rst = rst_n;

    sched_state_e         state_q, state_d;
    logic [COUNT_W-1:0]   count_q, count_d;
    logic [COUNT_W-1:0]   beats;
    logic [COUNT_W-1:0]   count_sum;
    logic                 start_acc;
    logic                 lane_ok;
    logic [NUM_LANES-1:0] full_vec, empty_vec, push_vec, pop_vec;
    logic [(1<<LANE_W)-1:0] full_ext;

    assign start_acc = start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign lane_ok   = (int'(in_lane) < NUM_LANES);

    always_comb begin
        full_ext                = '0;
        full_ext[NUM_LANES-1:0] = full_vec;
    end

    // Out-of-range lanes are always ready so the stream drains by dropping them.
    assign in_ready = (state_q == ST_RUN) && (!lane_ok || !full_ext[in_lane]);

    always_comb begin
        beats = '0;
        for (int i = 0; i < NUM_OUT; i++) beats = beats + COUNT_W'(out_write_valid[i]);
    end
    assign count_sum = count_q + beats;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_acc) begin
                    state_d = ST_FLUSH;
                    count_d = '0;
                end
            end
            ST_FLUSH: state_d = ST_RUN;
            ST_RUN: begin
                count_d = count_sum;
                if (count_sum >= COUNT_W'(OUT_TOTAL)) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    assign dut_flush = (state_q == ST_FLUSH);
    assign busy      = (state_q == ST_FLUSH) || (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign out_count = count_q;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            assign push_vec[gi] = in_valid && in_ready && (in_lane == LANE_W'(gi));
            assign pop_vec[gi]  = lane_read_en[gi] && (state_q != ST_FLUSH);

            resnet88_lane_fifo #(
                .DEPTH  (DEPTH),
                .DATA_W (DATA_W)
            ) u_fifo (
                .clk     (clk),
                .rst     (rst),
                .push_i  (push_vec[gi]),
                .pop_i   (pop_vec[gi]),
                .clear_i (start_acc),
                .wdata_i (in_data),
                .full_o  (full_vec[gi]),
                .empty_o (empty_vec[gi]),
                .head_o  (lane_data[gi*DATA_W +: DATA_W])
            );
        end
    endgenerate

`ifdef RESNET88_STREAM_SCHED_UNDERFLOW_CHECK_EN
    logic              err_q, err_d;
    logic [LANE_W-1:0] err_lane_q, err_lane_d;
    logic [NUM_LANES-1:0] uf_vec;
    logic [LANE_W-1:0] uf_low;

    assign uf_vec = (state_q == ST_RUN) ? (lane_read_en & empty_vec) : '0;

    // Walk downward so the lowest offending lane is the last one written.
    always_comb begin
        uf_low = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (uf_vec[i]) uf_low = LANE_W'(i);
        end
    end

    always_comb begin
        err_d      = err_q;
        err_lane_d = err_lane_q;
        if (start_acc) begin
            err_d      = 1'b0;
            err_lane_d = '0;
        end else if (!err_q && (uf_vec != '0)) begin
            err_d      = 1'b1;
            err_lane_d = uf_low;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q      <= 1'b0;
            err_lane_q <= '0;
        end else begin
            err_q      <= err_d;
            err_lane_q <= err_lane_d;
        end
    end

    assign underflow_err  = err_q;
    assign underflow_lane = err_lane_q;
`else
    assign underflow_err  = 1'b0;
    assign underflow_lane = '0;
`endif

endmodule

// File: tb/tb_resnet88_stream_sched.sv
// Directed self-checking bench for resnet88_stream_sched (OUT_TOTAL overridden to 16).
module tb_resnet88_stream_sched;
    localparam int NL = 9;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_lane;
    logic [15:0]   in_data;
    logic [NL-1:0] lane_read_en;
    logic [NL*16-1:0] lane_data;
    logic [7:0]    out_write_valid;
    logic          dut_flush, busy, done;
    logic [31:0]   out_count;
    logic          underflow_err;
    logic [3:0]    underflow_lane;

    int checks   = 0;
    int failures = 0;

    resnet88_stream_sched #(
        .NUM_LANES (9),
        .NUM_OUT   (8),
        .DEPTH     (4),
        .OUT_TOTAL (16)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_lane         (in_lane),
        .in_data         (in_data),
        .lane_read_en    (lane_read_en),
        .lane_data       (lane_data),
        .out_write_valid (out_write_valid),
        .dut_flush       (dut_flush),
        .busy            (busy),
        .done            (done),
        .out_count       (out_count),
        .underflow_err   (underflow_err),
        .underflow_lane  (underflow_lane)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] lane(input int i);
        return lane_data[i*16 +: 16];
    endfunction

    initial begin
        rst_n = 1'b1; start = 0; in_valid = 0; in_lane = 0; in_data = 0;
        lane_read_en = '0; out_write_valid = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_lane_data0", 32'(lane(0)), 0);
        chk("rst_flush", 32'(dut_flush), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_count", out_count, 0);
        chk("rst_uf_err", 32'(underflow_err), 0);
        tick();

        // Start: flush for exactly one cycle, then RUN
        start = 1; tick(); start = 0;
        in_lane = 3;
        chk("flush_hi", 32'(dut_flush), 1);
        chk("flush_busy", 32'(busy), 1);
        chk("flush_in_ready", 32'(in_ready), 0);
        tick();
        chk("run_flush_lo", 32'(dut_flush), 0);
        chk("run_busy", 32'(busy), 1);
        chk("run_count0", out_count, 0);

        // Fill lane 3
        in_valid = 1;
        for (int k = 1; k <= 4; k++) begin
            in_data = 16'(16'h1111 * k);
            #1 chk($sformatf("l3_ready_%0d", k), 32'(in_ready), 1);
            tick();
        end
        in_valid = 0;
        chk("l3_full_ready", 32'(in_ready), 0);
        chk("l3_head0", 32'(lane(3)), 32'h1111);
        lane_read_en = 9'h008;
        tick(); chk("l3_pop1", 32'(lane(3)), 32'h2222);
        tick(); chk("l3_pop2", 32'(lane(3)), 32'h3333);
        tick(); chk("l3_pop3", 32'(lane(3)), 32'h4444);
        tick(); chk("l3_pop4", 32'(lane(3)), 32'h0000);
        chk("l3_ready_back", 32'(in_ready), 1);
        tick(); chk("l3_empty_pop", 32'(lane(3)), 32'h0000);
        lane_read_en = '0;

        // Fill lane 8, then push+pop while full
        in_lane = 8; in_valid = 1;
        for (int k = 0; k < 4; k++) begin
            in_data = 16'(16'hA000 + k);
            tick();
        end
        in_data = 16'hA004; lane_read_en = 9'h100;
        #1 chk("l8_full_ready", 32'(in_ready), 0);
        tick();
        lane_read_en = '0;
        chk("l8_head_after_pop", 32'(lane(8)), 32'hA001);
        chk("l8_ready_occ3", 32'(in_ready), 1);
        tick();
        in_valid = 0;
        chk("l8_refull", 32'(in_ready), 0);
        lane_read_en = 9'h100;
        tick(); chk("l8_pop_a2", 32'(lane(8)), 32'hA002);
        tick(); chk("l8_pop_a3", 32'(lane(8)), 32'hA003);
        tick(); chk("l8_pop_a4", 32'(lane(8)), 32'hA004);
        tick(); chk("l8_pop_empty", 32'(lane(8)), 32'h0000);
        lane_read_en = '0;

        // Out-of-range lane: accepted and dropped
        in_lane = 12; in_valid = 1; in_data = 16'hDEAD;
        #1 chk("drop_ready", 32'(in_ready), 1);
        tick();
        in_valid = 0;
        chk("drop_lanes_zero", 32'(lane_data == '0), 1);
        chk("drop_count", out_count, 0);

        // Output counting to OUT_TOTAL=16
        out_write_valid = 8'hFF;
        tick();
        chk("cnt_8", out_count, 8);
        chk("cnt_not_done", 32'(done), 0);
        tick();
        chk("cnt_16", out_count, 16);
        chk("cnt_done", 32'(done), 1);
        chk("cnt_busy_lo", 32'(busy), 0);
        tick();
        chk("cnt_hold_16", out_count, 16);
        in_lane = 0;
        chk("done_in_ready", 32'(in_ready), 0);
        out_write_valid = '0;

        // Restart from DONE, then a partial popcount
        start = 1; tick(); start = 0;
        chk("restart_count0", out_count, 0);
        chk("restart_done_lo", 32'(done), 0);
        tick();
        out_write_valid = 8'h15;
        tick();
        out_write_valid = '0;
        chk("cnt_partial3", out_count, 3);

        // Underflow on lanes 2 and 5 with all FIFOs empty
        lane_read_en = 9'h024;
        tick();
        lane_read_en = 9'h001;
`ifdef RESNET88_STREAM_SCHED_UNDERFLOW_CHECK_EN
        chk("uf_err", 32'(underflow_err), 1);
        chk("uf_lane", 32'(underflow_lane), 2);
        tick();
        chk("uf_err_held", 32'(underflow_err), 1);
        chk("uf_lane_first", 32'(underflow_lane), 2);
`else
        chk("uf_err_off", 32'(underflow_err), 0);
        chk("uf_lane_off", 32'(underflow_lane), 0);
        tick();
`endif
        lane_read_en = '0;

        // Push to lane 0, then asynchronous reset mid-run
        in_lane = 0; in_valid = 1; in_data = 16'hBEEF;
        tick();
        in_valid = 0;
        chk("pre_rst_lane0", 32'(lane(0)), 32'hBEEF);
        #2 rst_n = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_count", out_count, 0);
        chk("arst_lane0", 32'(lane(0)), 0);
        chk("arst_uf_err", 32'(underflow_err), 0);
        chk("arst_uf_lane", 32'(underflow_lane), 0);
        tick();
        rst_n = 1'b0;
        tick();
        chk("post_rst_idle", 32'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
